spi_master_arbiter: RTL

- Sequences the ATmega-style SPI master peripheral through its register bus (SPCR/SPSR/SPDR) on behalf of two byte-stream requesters, e.g. the OLED display path and the flash loader.
- Performs one-shot SPCR configuration after reset.
- Round-robin arbitrates between the requesters and drives one active-low chip select per requester.
- Per byte: writes SPDR, polls SPSR.SPIF, reads SPDR back and returns the received byte.

---
 rtl/spi_master_arbiter_pkg.sv | 21 ++
 rtl/spi_master_arbiter_rr_arb2.sv | 39 +++
 rtl/spi_master_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/spi_master_arbiter_pkg.sv
// rtl/spi_master_arbiter_pkg.sv - shared state encoding and SPI register bit positions
// Imported by the arbiter top and its round-robin sub-module.
package spi_master_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_POLL,
    ST_READ,
    ST_DONE
  } state_t;

  localparam int SPIF_BIT = 7;
  localparam int EN_BIT   = 6;
  localparam int MSTR_BIT = 4;

  // Enabled master, mode 0, MSB first, fosc/4.
  localparam logic [7:0] SPCR_INIT_DEFAULT = 8'((1 << EN_BIT) | (1 << MSTR_BIT));

endpackage

// File: rtl/spi_master_arbiter_rr_arb2.sv
// rtl/spi_master_arbiter_rr_arb2.sv - 2-way round-robin arbiter with lock and last-grant register
// A held lock restricts the grant to the locked requester.
module spi_rr_arb2
  import spi_master_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock_en,
  input  logic       lock_id,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (lock_en) begin
      gnt[lock_id] = req[lock_id];
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // last=1 means requester 1 was served most recently, so requester 0 is favoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - sequences the SPI master registers for two byte-stream requesters
// Optional SPIF poll watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter
  import spi_master_arbiter_pkg::*;
#(
  parameter int         BUS_ADDR_DATA_LEN = 6,
  parameter int         SPCR_ADDR         = 0,
  parameter int         SPSR_ADDR         = 1,
  parameter int         SPDR_ADDR         = 2,
  parameter logic [7:0] SPCR_INIT         = SPCR_INIT_DEFAULT,
  parameter int         TIMEOUT_CYCLES    = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0_valid,
  input  logic [7:0]                   req0_data,
  input  logic                         req0_cs_hold,
  output logic                         req0_ready,
  output logic [7:0]                   req0_rdata,
  output logic                         req0_rvalid,
  input  logic                         req1_valid,
  input  logic [7:0]                   req1_data,
  input  logic                         req1_cs_hold,
  output logic                         req1_ready,
  output logic [7:0]                   req1_rdata,
  output logic                         req1_rvalid,
  output logic                         cs0_n,
  output logic                         cs1_n,
  output logic [BUS_ADDR_DATA_LEN-1:0] spi_addr,
  output logic                         spi_wr,
  output logic                         spi_rd,
  output logic [7:0]                   spi_wdata,
  input  logic [7:0]                   spi_rdata,
  output logic                         busy,
  output logic                         err
);

  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_SPCR = BUS_ADDR_DATA_LEN'(SPCR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_SPSR = BUS_ADDR_DATA_LEN'(SPSR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_SPDR = BUS_ADDR_DATA_LEN'(SPDR_ADDR);

  state_t     state, state_d;
  logic       owner, hold_q, lock_en, gap_q, tmo_hit, cs_active;
  logic [7:0] data_q, rdata0_q, rdata1_q;
  logic [1:0] gnt;

  spi_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid} & {2{state == ST_IDLE}}),
    .lock_en (lock_en),
    .lock_id (owner),
    .gnt     (gnt)
  );

  always_comb begin
    state_d   = state;
    spi_wr    = 1'b0;
    spi_rd    = 1'b0;
    spi_addr  = '0;
    spi_wdata = 8'h00;
    case (state)
      ST_INIT: begin
        // INIT is also the reset state; keep the bus quiet while rst is held.
        if (!rst) begin
          spi_wr    = 1'b1;
          spi_addr  = A_SPCR;
          spi_wdata = SPCR_INIT;
        end
        state_d = ST_IDLE;
      end
      ST_IDLE:  if (|gnt) state_d = ST_WRITE;
      ST_WRITE: begin
        spi_wr    = 1'b1;
        spi_addr  = A_SPDR;
        spi_wdata = data_q;
        state_d   = ST_POLL;
      end
      ST_POLL: begin
        spi_rd   = 1'b1;
        spi_addr = A_SPSR;
        if (spi_rdata[SPIF_BIT]) state_d = ST_READ;
        else if (tmo_hit)        state_d = ST_DONE;
      end
      ST_READ: begin
        // First READ cycle leaves rd low so the peripheral sees a falling edge.
        if (!gap_q) begin
          spi_rd   = 1'b1;
          spi_addr = A_SPDR;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      owner    <= 1'b0;
      hold_q   <= 1'b0;
      lock_en  <= 1'b0;
      gap_q    <= 1'b0;
      data_q   <= 8'h00;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
    end else begin
      state <= state_d;
      gap_q <= (state == ST_POLL) && (state_d == ST_READ);
      if (|gnt) begin
        owner  <= gnt[1];
        data_q <= gnt[1] ? req1_data : req0_data;
        hold_q <= gnt[1] ? req1_cs_hold : req0_cs_hold;
      end
      if (state == ST_READ && !gap_q) begin
        if (owner) rdata1_q <= spi_rdata;
        else       rdata0_q <= spi_rdata;
      end
      // Aborted byte: return 8'hFF and drop any lock so CS is released.
      if (state == ST_POLL && state_d == ST_DONE) begin
        hold_q <= 1'b0;
        if (owner) rdata1_q <= 8'hFF;
        else       rdata0_q <= 8'hFF;
      end
      if (state == ST_DONE) lock_en <= hold_q;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == ST_POLL) ? tmo_cnt + 1'b1 : '0;
      if (state == ST_POLL && state_d == ST_DONE) err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_out_of_range
  end
`endif

  assign cs_active = (state inside {ST_WRITE, ST_POLL, ST_READ, ST_DONE}) ||
                     (state == ST_IDLE && lock_en);
  assign cs0_n       = !((cs_active && !owner) || gnt[0]);
  assign cs1_n       = !((cs_active && owner) || gnt[1]);
  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];
  assign req0_rvalid = (state == ST_DONE) && !owner;
  assign req1_rvalid = (state == ST_DONE) && owner;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign busy        = (state != ST_IDLE);

endmodule
